// File: rtl/p_pipe.sv
`default_nettype none
// ============================================================================
// Module   : p_pipe
// Purpose  : 8-bit, four-stage (IF, ID, EX, WB) pipelined processor core
//            with a built-in 64x8 program ROM and an 8x8 register file.
//            ISA: ADD rd,rs / MOV rd,rs / SLL rd,rs / JMP target.
//            JMP resolves in ID and costs exactly one bubble.
// Ports    : clk   - rising-edge clock for all state
//            reset - asynchronous, active-low reset
// Observed : pc (8-bit program counter), reg_file[0:7] (hierarchical)
// Macro    : FORWARDING_EN - when defined, the EX/WB result is forwarded to
//            EX operands and the pipeline never stalls; when undefined, an
//            interlock stalls ID for one cycle on an EX-stage dependency.
// Revision : 1.0 - initial release
// ============================================================================
module p_pipe (
  input logic clk,
  input logic reset
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // Architectural state
  logic [7:0] pc;
  logic [7:0] reg_file [0:7];

  // IF/ID
  logic       r_ifid_valid;
  logic [7:0] r_ifid_instr;

  // ID/EX
  logic       r_idex_valid;
  logic [1:0] r_idex_op;
  logic [2:0] r_idex_rd;
  logic [7:0] r_idex_a;
  logic [7:0] r_idex_b;
`ifdef FORWARDING_EN
  logic [2:0] r_idex_rs;
`endif

  // EX/WB
  logic       r_exwb_valid;
  logic       r_exwb_we;
  logic [2:0] r_exwb_rd;
  logic [7:0] r_exwb_result;

  function automatic logic [7:0] rom_lookup(input logic [5:0] addr);
    case (addr)
      6'd0:    rom_lookup = 8'h0A;  // ADD R1,R2
      6'd1:    rom_lookup = 8'h59;  // MOV R3,R1
      6'd2:    rom_lookup = 8'h99;  // SLL R3,R1
      6'd3:    rom_lookup = 8'hC3;  // JMP 3
      default: rom_lookup = 8'h00;  // ADD R0,R0
    endcase
  endfunction

  // ROM read and write-back port kept as nets so they can be observed
  // and overridden from outside without touching the flops.
  wire [7:0] w_rom_data = rom_lookup(pc[5:0]);
  wire       w_wb_en    = r_exwb_valid & r_exwb_we;
  wire [2:0] w_wb_rd    = r_exwb_rd;
  wire [7:0] w_wb_data  = r_exwb_result;

  // ---------------------------------------------------------------- ID stage
  logic [1:0] w_id_op;
  logic [2:0] w_id_rd;
  logic [2:0] w_id_rs;
  logic       w_id_reads_rd;
  logic       w_id_reads_rs;
  logic [7:0] w_id_a;
  logic [7:0] w_id_b;
  logic       w_stall;
  logic       w_jump;

  always_comb begin
    w_id_op       = r_ifid_instr[7:6];
    w_id_rd       = r_ifid_instr[5:3];
    w_id_rs       = r_ifid_instr[2:0];
    w_id_reads_rd = r_ifid_valid && ((w_id_op == OP_ADD) || (w_id_op == OP_SLL));
    w_id_reads_rs = r_ifid_valid && (w_id_op != OP_JMP);
    // Write-through: a same-cycle WB write is visible to the ID read.
    w_id_a = (w_wb_en && (w_wb_rd == w_id_rd)) ? w_wb_data : reg_file[w_id_rd];
    w_id_b = (w_wb_en && (w_wb_rd == w_id_rs)) ? w_wb_data : reg_file[w_id_rs];
`ifdef FORWARDING_EN
    w_stall = 1'b0;
`else
    // Interlock on a dependency against the instruction currently in EX.
    w_stall = r_idex_valid && (r_idex_op != OP_JMP) &&
              ((w_id_reads_rd && (r_idex_rd == w_id_rd)) ||
               (w_id_reads_rs && (r_idex_rd == w_id_rs)));
`endif
    // A stall outranks the jump; the JMP simply waits in ID.
    w_jump = r_ifid_valid && (w_id_op == OP_JMP) && !w_stall;
  end

  // ---------------------------------------------------------------- EX stage
  logic [7:0] w_ex_a;
  logic [7:0] w_ex_b;
  logic [7:0] w_ex_result;

  always_comb begin
    w_ex_a = r_idex_a;
    w_ex_b = r_idex_b;
`ifdef FORWARDING_EN
    if (w_wb_en && (w_wb_rd == r_idex_rd)) w_ex_a = w_wb_data;
    if (w_wb_en && (w_wb_rd == r_idex_rs)) w_ex_b = w_wb_data;
`endif
    case (r_idex_op)
      OP_ADD:  w_ex_result = w_ex_a + w_ex_b;
      OP_MOV:  w_ex_result = w_ex_b;
      OP_SLL:  w_ex_result = w_ex_a << w_ex_b[2:0];
      default: w_ex_result = 8'h00;
    endcase
  end

  // ------------------------------------------------------------- sequential
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= 8'h00;
      r_ifid_valid  <= 1'b0;
      r_ifid_instr  <= 8'h00;
      r_idex_valid  <= 1'b0;
      r_idex_op     <= OP_ADD;
      r_idex_rd     <= 3'd0;
      r_idex_a      <= 8'h00;
      r_idex_b      <= 8'h00;
`ifdef FORWARDING_EN
      r_idex_rs     <= 3'd0;
`endif
      r_exwb_valid  <= 1'b0;
      r_exwb_we     <= 1'b0;
      r_exwb_rd     <= 3'd0;
      r_exwb_result <= 8'h00;
      for (int i = 0; i < 8; i++) reg_file[i] <= 8'(i);
    end else begin
      // WB
      if (w_wb_en) reg_file[w_wb_rd] <= w_wb_data;

      // EX -> EX/WB
      r_exwb_valid  <= r_idex_valid;
      r_exwb_we     <= r_idex_valid && (r_idex_op != OP_JMP);
      r_exwb_rd     <= r_idex_rd;
      r_exwb_result <= w_ex_result;

      // ID -> ID/EX (bubble during a stall)
      r_idex_valid <= r_ifid_valid && !w_stall;
      r_idex_op    <= w_id_op;
      r_idex_rd    <= w_id_rd;
      r_idex_a     <= w_id_a;
      r_idex_b     <= w_id_b;
`ifdef FORWARDING_EN
      r_idex_rs    <= w_id_rs;
`endif

      // IF: a taken jump flushes the fetch behind it; a stall holds IF.
      if (w_jump) begin
        pc           <= {2'b00, r_ifid_instr[5:0]};
        r_ifid_valid <= 1'b0;
      end else if (!w_stall) begin
        pc           <= pc + 8'd1;
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= w_rom_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_p_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_pipe
// Purpose  : Self-checking bench for p_pipe. Expected register writes are
//            queued with their commit edge; a monitor pops and compares on
//            every write-back. Direct checks cover reset and steady state.
// Macro    : FORWARDING_EN selects the expected commit edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_p_pipe;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  p_pipe dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    int         edge_no;
    logic [2:0] rd;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec  = 0;
  int  n_err  = 0;
  int  cyc    = 0;
  int  base   = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, 32'(dut.pc), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(dut.reg_file[i]), 32'(i));
  endtask

  // Monitor: the write visible at this negedge commits at the next edge.
  always @(negedge clk) begin
    if (mon_en && reset && dut.w_wb_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got R%0d=%0d at edge %0d expected no write",
                 dut.w_wb_rd, dut.w_wb_data, cyc - base + 1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_edge", 32'(cyc - base + 1), 32'(e.edge_no));
        check("wb_rd",   32'(dut.w_wb_rd),    32'(e.rd));
        check("wb_data", 32'(dut.w_wb_data),  32'(e.data));
      end
    end
  end

  initial begin
    int  k;
    bit  found;
    logic [7:0] exp_pc;
    logic [7:0] exp_regs [0:7];

    // Power-on reset held low
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");

    // Partial run, then asynchronous re-assert mid-cycle
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("prerun_r1", 32'(dut.reg_file[1]), 32'd3);
    reset = 1'b0;
    #1;
    check_reset("midrun");
    repeat (2) @(negedge clk);

    // Main run with scoreboard
`ifdef FORWARDING_EN
    exp_q.push_back('{4, 3'd1, 8'd3});
    exp_q.push_back('{5, 3'd3, 8'd3});
    exp_q.push_back('{6, 3'd3, 8'd24});
`else
    exp_q.push_back('{4, 3'd1, 8'd3});
    exp_q.push_back('{6, 3'd3, 8'd3});
    exp_q.push_back('{8, 3'd3, 8'd24});
`endif
    base   = cyc;
    mon_en = 1'b1;
    reset  = 1'b1;
    repeat (25) @(negedge clk);

    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    exp_regs = '{8'd0, 8'd3, 8'd2, 8'd24, 8'd4, 8'd5, 8'd6, 8'd7};
    for (int i = 0; i < 8; i++)
      check($sformatf("steady_r%0d", i), 32'(dut.reg_file[i]), 32'(exp_regs[i]));

    // pc alternates between 3 and 4
    check("pc_in_loop", 32'((dut.pc == 8'd3) || (dut.pc == 8'd4)), 32'd1);
    exp_pc = (dut.pc == 8'd3) ? 8'd4 : 8'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("pc_alternate", 32'(dut.pc), 32'(exp_pc));
      exp_pc = (exp_pc == 8'd3) ? 8'd4 : 8'd3;
    end

    // ADD wrap: inject R0 = 0xFF and replace the fetch at pc 3 by 0x00
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      #1;
      if (dut.pc == 8'd3) found = 1'b1;
    end
    check("inject_sync", 32'(found), 32'd1);
    if (found) begin
      k = cyc - base;
      exp_q.push_back('{k + 4, 3'd0, 8'hFE});
      force dut.w_wb_en    = 1'b1;
      force dut.w_wb_rd    = 3'd0;
      force dut.w_wb_data  = 8'hFF;
      force dut.w_rom_data = 8'h00;
      @(posedge clk);
      #1;
      release dut.w_wb_en;
      release dut.w_wb_rd;
      release dut.w_wb_data;
      release dut.w_rom_data;
      check("r0_injected", 32'(dut.reg_file[0]), 32'hFF);
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("r0_add_wrap", 32'(dut.reg_file[0]), 32'hFE);
    end
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
